// File: rtl/demux1to16_5bit_reg_if.sv
// Bus bundle for the 16-slot, 5-bit write-steering register bank.
// The master side drives write data/controls; the slave side (the bank)
// returns the slot contents and the bookkeeping status.
interface demux1to16_5bit_reg_if;
    // Write-side controls
    logic [4:0]  In;
    logic [3:0]  Sel;
    logic        WrEn;
    logic        AutoInc;
    logic        LoadPtr;
    logic        Clear;

    // Registered slot contents
    logic [4:0]  O0,  O1,  O2,  O3,  O4,  O5,  O6,  O7;
    logic [4:0]  O8,  O9,  O10, O11, O12, O13, O14, O15;

    // Status
    logic [15:0] Valid;
    logic        Full;
    logic [3:0]  Ptr;
    logic        WrAck;
    logic [3:0]  LastIdx;

    modport master (
        output In, Sel, WrEn, AutoInc, LoadPtr, Clear,
        input  O0, O1, O2, O3, O4, O5, O6, O7,
        input  O8, O9, O10, O11, O12, O13, O14, O15,
        input  Valid, Full, Ptr, WrAck, LastIdx
    );

    modport slave (
        input  In, Sel, WrEn, AutoInc, LoadPtr, Clear,
        output O0, O1, O2, O3, O4, O5, O6, O7,
        output O8, O9, O10, O11, O12, O13, O14, O15,
        output Valid, Full, Ptr, WrAck, LastIdx
    );
endinterface

// File: rtl/demux1to16_5bit_reg.sv
// 1-to-16 registered demultiplexer for 5-bit values.
// A write lands in the slot chosen by Sel (direct) or by the internal
// pointer (AutoInc), which then advances modulo 16. Clear wins over
// LoadPtr, which wins over a write; LoadPtr together with an auto write
// drops that write. Each slot tracks whether it has been written since the
// last reset/Clear; Full is the AND of those flags.
module demux1to16_5bit_reg #(
    parameter logic [4:0] RST_VAL = 5'd0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    demux1to16_5bit_reg_if.slave          bus
);

    logic [4:0]  slots_q [16];
    logic [4:0]  slots_d [16];
    logic [15:0] valid_q, valid_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        wrack_q, wrack_d;
    logic [3:0]  lastidx_q, lastidx_d;

    logic        wr_ok_s;
    logic [3:0]  tgt_s;

    // Decide whether this edge accepts a write and which slot it targets.
    always_comb begin
        wr_ok_s = 1'b0;
        tgt_s   = bus.Sel;
        if (bus.Clear) begin
            wr_ok_s = 1'b0;
        end else if (bus.WrEn && !bus.AutoInc) begin
            wr_ok_s = 1'b1;
            tgt_s   = bus.Sel;
        end else if (bus.WrEn && bus.AutoInc && !bus.LoadPtr) begin
            wr_ok_s = 1'b1;
            tgt_s   = ptr_q;
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    // Next-state for slots, flags, pointer and acknowledge.
    always_comb begin
        slots_d   = slots_q;
        valid_d   = valid_q;
        ptr_d     = ptr_q;
        wrack_d   = 1'b0;
        lastidx_d = lastidx_q;
        if (bus.Clear) begin
            for (int k = 0; k < 16; k++) begin
                slots_d[k] = RST_VAL;
            end
            valid_d = 16'h0000;
            ptr_d   = 4'd0;
        end else begin
            if (bus.LoadPtr) begin
                ptr_d = bus.Sel;
            end else if (bus.WrEn && bus.AutoInc) begin
                ptr_d = ptr_q + 4'd1;
            end else begin
                ptr_d = ptr_q;
            end
            // In only reaches a slot on an accepted write, so an unknown
            // In with WrEn low never propagates.
            if (wr_ok_s) begin
                slots_d[tgt_s] = bus.In;
                valid_d[tgt_s] = 1'b1;
                wrack_d        = 1'b1;
                lastidx_d      = tgt_s;
            end else begin
                wrack_d        = 1'b0;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) begin
                slots_q[k] <= RST_VAL;
            end
            valid_q   <= 16'h0000;
            ptr_q     <= 4'd0;
            wrack_q   <= 1'b0;
            lastidx_q <= 4'd0;
        end else begin
            slots_q   <= slots_d;
            valid_q   <= valid_d;
            ptr_q     <= ptr_d;
            wrack_q   <= wrack_d;
            lastidx_q <= lastidx_d;
        end
    end

    assign bus.O0      = slots_q[0];
    assign bus.O1      = slots_q[1];
    assign bus.O2      = slots_q[2];
    assign bus.O3      = slots_q[3];
    assign bus.O4      = slots_q[4];
    assign bus.O5      = slots_q[5];
    assign bus.O6      = slots_q[6];
    assign bus.O7      = slots_q[7];
    assign bus.O8      = slots_q[8];
    assign bus.O9      = slots_q[9];
    assign bus.O10     = slots_q[10];
    assign bus.O11     = slots_q[11];
    assign bus.O12     = slots_q[12];
    assign bus.O13     = slots_q[13];
    assign bus.O14     = slots_q[14];
    assign bus.O15     = slots_q[15];
    assign bus.Valid   = valid_q;
    assign bus.Full    = &valid_q;
    assign bus.Ptr     = ptr_q;
    assign bus.WrAck   = wrack_q;
    assign bus.LastIdx = lastidx_q;

endmodule
